// File: rtl/ibex_pkg.sv
// Shared types for the custom (bloom-filter) instruction issue path.
package ibex_pkg;

  typedef enum logic [4:0] {
    CUSTOM_OP_NONE       = 5'd0,
    CUSTOM_OP_BLOOM_ADD  = 5'd1,
    CUSTOM_OP_BLOOM_TEST = 5'd2,
    CUSTOM_OP_BLOOM_CLR  = 5'd3,
    CUSTOM_OP_BLOOM_HASH = 5'd4
  } custom_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WB    = 3'd3,
    DRAIN = 3'd4
  } custom_issue_state_e;

endpackage

// File: rtl/ibex_custom_timeout_cnt.sv
// Wait-cycle counter for the custom issue stage; only instantiated when
// IBEX_CUSTOM_TIMEOUT_EN is defined.
module ibex_custom_timeout_cnt #(
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] Limit = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign expired_o = (cnt_q == Limit);

  // Saturate at the limit so a lingering enable can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ibex_custom_issue.sv
// Issue/retire stage for custom ops in front of the EX custom unit.
// Optional wait timeout enabled by defining IBEX_CUSTOM_TIMEOUT_EN.
module ibex_custom_issue
  import ibex_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_req_i,
  input  custom_op_e  id_op_i,
  input  logic [31:0] id_rs1_i,
  input  logic [31:0] id_rs2_i,
  input  logic [4:0]  id_rd_addr_i,
  output logic        id_ready_o,
  output logic        id_stall_o,
  output logic        id_done_o,
  input  logic        flush_i,
  output logic        custom_en_o,
  output custom_op_e  custom_op_o,
  output logic [31:0] custom_rs1_o,
  output logic [31:0] custom_rs2_o,
  input  logic        custom_valid_i,
  input  logic [31:0] custom_result_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_wdata_o,
  output logic        err_o
);

  custom_issue_state_e state_d, state_q;
  custom_op_e          op_d, op_q;
  logic [31:0]         rs1_d, rs1_q;
  logic [31:0]         rs2_d, rs2_q;
  logic [4:0]          rd_d, rd_q;
  logic [31:0]         result_d, result_q;
  logic                err_d, err_q;
  logic                tdone_d, tdone_q;
  logic                cnt_expired;

`ifdef IBEX_CUSTOM_TIMEOUT_EN
  logic cnt_clear;
  logic cnt_enable;

  assign cnt_clear  = (state_d != state_q) && ((state_d == WAIT) || (state_d == DRAIN));
  assign cnt_enable = (state_q == WAIT) || (state_q == DRAIN);

  ibex_custom_timeout_cnt #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_enable),
    .expired_o (cnt_expired)
  );
`else
  logic unused_timeout;

  assign unused_timeout = (TimeoutCycles == 32'd0);
  assign cnt_expired    = 1'b0;
`endif

  // Flush takes priority over a same-cycle completion; a timeout only fires
  // when neither flush nor completion arrived in that cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    result_d = result_q;
    err_d    = 1'b0;
    tdone_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (id_req_i) begin
          op_d    = id_op_i;
          rs1_d   = id_rs1_i;
          rs2_d   = id_rs2_i;
          rd_d    = id_rd_addr_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (custom_valid_i) begin
          result_d = custom_result_i;
          state_d  = WB;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_d = DRAIN;
        end else if (custom_valid_i) begin
          result_d = custom_result_i;
          state_d  = WB;
        end else if (cnt_expired) begin
          err_d   = 1'b1;
          tdone_d = 1'b1;
          state_d = IDLE;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (custom_valid_i) begin
          state_d = IDLE;
        end else if (cnt_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= CUSTOM_OP_NONE;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      tdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      err_q    <= err_d;
      tdone_q  <= tdone_d;
    end
  end

  assign id_ready_o   = (state_q == IDLE);
  assign id_stall_o   = (state_q != IDLE);
  assign id_done_o    = (state_q == WB) || tdone_q;
  assign custom_en_o  = (state_q == ISSUE) && !flush_i;
  assign custom_op_o  = op_q;
  assign custom_rs1_o = rs1_q;
  assign custom_rs2_o = rs2_q;
  // Register-file port is quiet outside WB so x0 and idle cycles never leak data.
  assign wb_we_o      = (state_q == WB) && (rd_q != 5'd0);
  assign wb_addr_o    = (state_q == WB) ? rd_q : 5'd0;
  assign wb_wdata_o   = (state_q == WB) ? result_q : 32'd0;
  assign err_o        = err_q;

endmodule

// File: tb/tb_ibex_custom_issue.sv
// Self-checking bench for ibex_custom_issue: directed scenarios plus a
// randomized op stream checked against a transaction-level timing model.
module tb_ibex_custom_issue;
  import ibex_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        id_req_i = 1'b0;
  custom_op_e  id_op_i = CUSTOM_OP_NONE;
  logic [31:0] id_rs1_i = '0;
  logic [31:0] id_rs2_i = '0;
  logic [4:0]  id_rd_addr_i = '0;
  logic        id_ready_o, id_stall_o, id_done_o;
  logic        flush_i = 1'b0;
  logic        custom_en_o;
  custom_op_e  custom_op_o;
  logic [31:0] custom_rs1_o, custom_rs2_o;
  logic        custom_valid_i = 1'b0;
  logic [31:0] custom_result_i = '0;
  logic        wb_we_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_wdata_o;
  logic        err_o;

  ibex_custom_issue #(.TimeoutCycles(TO)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .id_req_i        (id_req_i),
    .id_op_i         (id_op_i),
    .id_rs1_i        (id_rs1_i),
    .id_rs2_i        (id_rs2_i),
    .id_rd_addr_i    (id_rd_addr_i),
    .id_ready_o      (id_ready_o),
    .id_stall_o      (id_stall_o),
    .id_done_o       (id_done_o),
    .flush_i         (flush_i),
    .custom_en_o     (custom_en_o),
    .custom_op_o     (custom_op_o),
    .custom_rs1_o    (custom_rs1_o),
    .custom_rs2_o    (custom_rs2_o),
    .custom_valid_i  (custom_valid_i),
    .custom_result_i (custom_result_i),
    .wb_we_o         (wb_we_o),
    .wb_addr_o       (wb_addr_o),
    .wb_wdata_o      (wb_wdata_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Observations of one op, indexed by cycle r relative to the accept cycle (r=0).
  int          en_cnt, en_first, wb_cnt, wb_at, done_cnt, done_at, err_cnt, err_at;
  int          ready_at, opnd_bad, stall_bad;
  logic [4:0]  wb_addr_s;
  logic [31:0] wb_data_s;

  // Drives one op: request at r=0, valid pulses at v_at/v2_at, flush at fl_at
  // (negative index = never); runs until id_ready_o returns or the budget ends.
  task automatic run_op(input custom_op_e op, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] rd, input int v_at, input int v2_at, input int fl_at,
                        input logic [31:0] res);
    en_cnt = 0; en_first = -1; wb_cnt = 0; wb_at = -1; done_cnt = 0; done_at = -1;
    err_cnt = 0; err_at = -1; ready_at = -1; opnd_bad = 0; stall_bad = 0;
    wb_addr_s = '0; wb_data_s = '0;
    for (int r = 0; r < 80; r++) begin
      @(posedge clk); #1;
      id_req_i        = (r == 0);
      id_op_i         = (r == 0) ? op : custom_op_e'(5'($urandom_range(0, 4)));
      id_rs1_i        = (r == 0) ? rs1 : $urandom;
      id_rs2_i        = (r == 0) ? rs2 : $urandom;
      id_rd_addr_i    = (r == 0) ? rd : 5'($urandom);
      custom_valid_i  = (r == v_at) || (r == v2_at);
      custom_result_i = (r == v_at) ? res : $urandom;
      flush_i         = (r == fl_at);
      #1;
      if (custom_en_o) begin en_cnt++; if (en_first < 0) en_first = r; end
      if (wb_we_o) begin wb_cnt++; wb_at = r; wb_addr_s = wb_addr_o; wb_data_s = wb_wdata_o; end
      if (id_done_o) begin done_cnt++; done_at = r; end
      if (err_o) begin err_cnt++; err_at = r; end
      if (id_stall_o === id_ready_o) stall_bad++;
      if (r > 0 && !id_ready_o &&
          (custom_op_o !== op || custom_rs1_o !== rs1 || custom_rs2_o !== rs2)) opnd_bad++;
      if (r > 0 && id_ready_o) begin ready_at = r; break; end
    end
    id_req_i = 1'b0; custom_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    tests_run++; if (id_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset ready got %b want 1", id_ready_o); end
    tests_run++; if (id_stall_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset stall got %b want 0", id_stall_o); end
    tests_run++; if (custom_en_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset en got %b want 0", custom_en_o); end
    tests_run++; if (wb_we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset wb_we got %b want 0", wb_we_o); end
    tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset err got %b want 0", err_o); end
    tests_run++; if (id_done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset done got %b want 0", id_done_o); end
    tests_run++; if (custom_rs1_o !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset rs1 got %h want 0", custom_rs1_o); end
    @(posedge clk); #1; rst_ni = 1'b1;
    repeat (2) @(posedge clk); #2;
    tests_run++; if (id_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset ready got %b want 1", id_ready_o); end
    tests_run++; if (custom_en_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset en got %b want 0", custom_en_o); end
  endtask

  task automatic test_basic_op();
    run_op(CUSTOM_OP_BLOOM_ADD, 32'hDEAD_BEEF, 32'h1234_5678, 5'd5, 5, -1, -1, 32'h1);
    tests_run++; if (en_cnt !== 1) begin tests_failed++; $display("[TB] FAIL basic en_cnt got %0d want 1", en_cnt); end
    tests_run++; if (en_first !== 1) begin tests_failed++; $display("[TB] FAIL basic en_at got %0d want 1", en_first); end
    tests_run++; if (wb_cnt !== 1 || wb_at !== 6) begin tests_failed++; $display("[TB] FAIL basic wb cnt/at got %0d/%0d want 1/6", wb_cnt, wb_at); end
    tests_run++; if (wb_addr_s !== 5'd5) begin tests_failed++; $display("[TB] FAIL basic wb_addr got %0d want 5", wb_addr_s); end
    tests_run++; if (wb_data_s !== 32'h1) begin tests_failed++; $display("[TB] FAIL basic wb_data got %h want 1", wb_data_s); end
    tests_run++; if (done_cnt !== 1 || done_at !== 6) begin tests_failed++; $display("[TB] FAIL basic done cnt/at got %0d/%0d want 1/6", done_cnt, done_at); end
    tests_run++; if (ready_at !== 7) begin tests_failed++; $display("[TB] FAIL basic ready_at got %0d want 7", ready_at); end
    tests_run++; if (opnd_bad !== 0 || stall_bad !== 0) begin tests_failed++; $display("[TB] FAIL basic hold/stall got %0d/%0d want 0/0", opnd_bad, stall_bad); end
  endtask

  task automatic test_rd_zero_fast();
    run_op(CUSTOM_OP_BLOOM_TEST, 32'hCAFE_0001, 32'h0, 5'd0, 1, -1, -1, 32'hFFFF_0000);
    tests_run++; if (wb_cnt !== 0) begin tests_failed++; $display("[TB] FAIL rd0 wb_cnt got %0d want 0", wb_cnt); end
    tests_run++; if (done_cnt !== 1 || done_at !== 2) begin tests_failed++; $display("[TB] FAIL rd0 done cnt/at got %0d/%0d want 1/2", done_cnt, done_at); end
    tests_run++; if (ready_at !== 3) begin tests_failed++; $display("[TB] FAIL rd0 ready_at got %0d want 3", ready_at); end
  endtask

  task automatic test_flush();
    run_op(CUSTOM_OP_BLOOM_CLR, 32'h11, 32'h22, 5'd9, -1, -1, 1, 32'h0);
    tests_run++; if (en_cnt !== 0) begin tests_failed++; $display("[TB] FAIL flush_issue en_cnt got %0d want 0", en_cnt); end
    tests_run++; if (done_cnt !== 0 || wb_cnt !== 0) begin tests_failed++; $display("[TB] FAIL flush_issue done/wb got %0d/%0d want 0/0", done_cnt, wb_cnt); end
    tests_run++; if (ready_at !== 2) begin tests_failed++; $display("[TB] FAIL flush_issue ready_at got %0d want 2", ready_at); end
    run_op(CUSTOM_OP_BLOOM_HASH, 32'h33, 32'h44, 5'd12, 6, -1, 3, 32'hABCD);
    tests_run++; if (en_cnt !== 1) begin tests_failed++; $display("[TB] FAIL flush_wait en_cnt got %0d want 1", en_cnt); end
    tests_run++; if (done_cnt !== 0 || wb_cnt !== 0) begin tests_failed++; $display("[TB] FAIL flush_wait done/wb got %0d/%0d want 0/0", done_cnt, wb_cnt); end
    tests_run++; if (ready_at !== 7) begin tests_failed++; $display("[TB] FAIL flush_wait ready_at got %0d want 7", ready_at); end
  endtask

  task automatic test_timeout();
`ifdef IBEX_CUSTOM_TIMEOUT_EN
    run_op(CUSTOM_OP_BLOOM_ADD, 32'h5, 32'h6, 5'd3, -1, -1, -1, 32'h0);
    tests_run++; if (err_cnt !== 1 || err_at !== 10) begin tests_failed++; $display("[TB] FAIL timeout_wait err cnt/at got %0d/%0d want 1/10", err_cnt, err_at); end
    tests_run++; if (done_cnt !== 1 || wb_cnt !== 0) begin tests_failed++; $display("[TB] FAIL timeout_wait done/wb got %0d/%0d want 1/0", done_cnt, wb_cnt); end
    tests_run++; if (ready_at !== 10) begin tests_failed++; $display("[TB] FAIL timeout_wait ready_at got %0d want 10", ready_at); end
    run_op(CUSTOM_OP_BLOOM_ADD, 32'h7, 32'h8, 5'd4, -1, -1, 3, 32'h0);
    tests_run++; if (err_cnt !== 1 || done_cnt !== 0) begin tests_failed++; $display("[TB] FAIL timeout_drain err/done got %0d/%0d want 1/0", err_cnt, done_cnt); end
    tests_run++; if (ready_at !== 12) begin tests_failed++; $display("[TB] FAIL timeout_drain ready_at got %0d want 12", ready_at); end
`else
    run_op(CUSTOM_OP_BLOOM_ADD, 32'h5, 32'h6, 5'd3, 30, -1, -1, 32'h77);
    tests_run++; if (err_cnt !== 0) begin tests_failed++; $display("[TB] FAIL long_wait err_cnt got %0d want 0", err_cnt); end
    tests_run++; if (wb_cnt !== 1 || wb_at !== 31) begin tests_failed++; $display("[TB] FAIL long_wait wb cnt/at got %0d/%0d want 1/31", wb_cnt, wb_at); end
    tests_run++; if (wb_data_s !== 32'h77) begin tests_failed++; $display("[TB] FAIL long_wait wb_data got %h want 77", wb_data_s); end
`endif
  endtask

  task automatic test_reset_mid_op();
    @(posedge clk); #1;
    id_req_i = 1'b1; id_op_i = CUSTOM_OP_BLOOM_TEST; id_rs1_i = 32'hA5A5_A5A5; id_rs2_i = 32'h1; id_rd_addr_i = 5'd7;
    @(posedge clk); #1; id_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #3; rst_ni = 1'b0; #1;
    tests_run++; if (id_ready_o !== 1'b1 || id_stall_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst ready/stall got %b/%b want 1/0", id_ready_o, id_stall_o); end
    tests_run++; if (custom_rs1_o !== 32'd0 || custom_en_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst rs1/en got %h/%b want 0/0", custom_rs1_o, custom_en_o); end
    @(posedge clk); #1; rst_ni = 1'b1;
    @(posedge clk); #1; custom_valid_i = 1'b1; custom_result_i = 32'h9999; #1;
    tests_run++; if (wb_we_o !== 1'b0 || id_done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_valid wb/done got %b/%b want 0/0", wb_we_o, id_done_o); end
    @(posedge clk); #1; custom_valid_i = 1'b0; #1;
    tests_run++; if (id_ready_o !== 1'b1 || wb_we_o !== 1'b0 || id_done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_after ready/wb/done got %b/%b/%b want 1/0/0", id_ready_o, wb_we_o, id_done_o); end
  endtask

  // Random ops: expected timeline derived from the op's rules (start one
  // cycle after accept, writeback one cycle after completion, flush aborts).
  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int mode, d, f, g, v_at, v2_at, fl_at;
      int exp_en, exp_wb, exp_done, exp_done_at, exp_ready;
      custom_op_e op;
      logic [31:0] rs1, rs2, res;
      logic [4:0] rd;
      mode = $urandom_range(0, 2);
      op = custom_op_e'(5'($urandom_range(0, 4)));
      rs1 = $urandom; rs2 = $urandom; res = $urandom;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      v2_at = -1; fl_at = -1;
      if (mode == 0) begin
        d = $urandom_range(0, 6);
        v_at = 1 + d;
        if ($urandom_range(0, 1) == 1) v2_at = 2 + d;
        exp_en = 1; exp_wb = (rd != 5'd0) ? 1 : 0; exp_done = 1; exp_done_at = 2 + d; exp_ready = 3 + d;
      end else if (mode == 1) begin
        fl_at = 1;
        v_at = ($urandom_range(0, 1) == 1) ? 1 : -1;
        exp_en = 0; exp_wb = 0; exp_done = 0; exp_done_at = -1; exp_ready = 2;
      end else begin
        f = $urandom_range(1, 4); g = $urandom_range(1, 4);
        fl_at = 1 + f; v_at = fl_at + g;
        if ($urandom_range(0, 1) == 1) v2_at = fl_at;
        exp_en = 1; exp_wb = 0; exp_done = 0; exp_done_at = -1; exp_ready = v_at + 1;
      end
      run_op(op, rs1, rs2, rd, v_at, v2_at, fl_at, res);
      tests_run++; if (en_cnt !== exp_en || (exp_en == 1 && en_first !== 1)) begin tests_failed++; $display("[TB] FAIL rand%0d en cnt/at got %0d/%0d want %0d/1", i, en_cnt, en_first, exp_en); end
      tests_run++; if (wb_cnt !== exp_wb) begin tests_failed++; $display("[TB] FAIL rand%0d wb_cnt got %0d want %0d", i, wb_cnt, exp_wb); end
      if (exp_wb == 1) begin
        tests_run++; if (wb_at !== exp_done_at || wb_addr_s !== rd || wb_data_s !== res) begin tests_failed++; $display("[TB] FAIL rand%0d wb at/addr/data got %0d/%0d/%h want %0d/%0d/%h", i, wb_at, wb_addr_s, wb_data_s, exp_done_at, rd, res); end
      end
      tests_run++; if (done_cnt !== exp_done || done_at !== exp_done_at) begin tests_failed++; $display("[TB] FAIL rand%0d done cnt/at got %0d/%0d want %0d/%0d", i, done_cnt, done_at, exp_done, exp_done_at); end
      tests_run++; if (ready_at !== exp_ready) begin tests_failed++; $display("[TB] FAIL rand%0d ready_at got %0d want %0d", i, ready_at, exp_ready); end
      tests_run++; if (err_cnt !== 0 || opnd_bad !== 0 || stall_bad !== 0) begin tests_failed++; $display("[TB] FAIL rand%0d err/hold/stall got %0d/%0d/%0d want 0/0/0", i, err_cnt, opnd_bad, stall_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_op();
    test_rd_zero_fast();
    test_flush();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
